// File: rtl/sim_uart_pkg.sv
// Shared types and helpers for the multi-channel UART receive hub.
// Receiver states, bit-period derivation and channel-index width.
package sim_uart_pkg;

    typedef enum logic [2:0] {
        Idle,
        Start,
        Data,
        Stop,
        Break
    } rx_state_e;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sim_uart_rx.sv
// Single-channel UART receiver: synchroniser, framing FSM, bit timer.
// Emits a one-cycle push with the byte, or a one-cycle framing-error pulse.
module sim_uart_rx
    import sim_uart_pkg::*;
#(
    parameter int ClksPerBit = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       push_o,
    output logic [7:0] data_o,
    output logic       frame_err_o
);

    localparam int CntW = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] HalfLoad = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] BitLoad  = CntW'(ClksPerBit - 1);

    logic [1:0]      sync_q;
    logic [1:0]      flush_q;
    logic            armed_q;
    rx_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            rs;

    assign rs = sync_q[1];

    // Two-flop synchroniser preset idle-high; flush_q marks when rs is real.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            flush_q <= 2'b00;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            flush_q <= {flush_q[0], 1'b1};
        end
    end

    // Framing FSM: mid-bit sampling, LSB first, waits for high line to arm.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= Idle;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            push_o      <= 1'b0;
            data_o      <= '0;
            frame_err_o <= 1'b0;
        end else begin
            push_o      <= 1'b0;
            frame_err_o <= 1'b0;
            unique case (state_q)
                Idle: begin
                    if (!armed_q) begin
                        if (flush_q[1]) begin
                            if (rs) armed_q <= 1'b1;
                            else    state_q <= Break;
                        end
                    end else if (!rs) begin
                        state_q <= Start;
                        cnt_q   <= HalfLoad;
                    end
                end
                Start: begin
                    if (cnt_q == '0) begin
                        if (!rs) begin
                            state_q <= Data;
                            cnt_q   <= BitLoad;
                            bit_q   <= '0;
                        end else begin
                            state_q <= Idle;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                Data: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rs, shift_q[7:1]};
                        cnt_q   <= BitLoad;
                        if (bit_q == 3'd7) state_q <= Stop;
                        else               bit_q   <= bit_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                Stop: begin
                    if (cnt_q == '0) begin
                        if (rs) begin
                            push_o  <= 1'b1;
                            data_o  <= shift_q;
                            state_q <= Idle;
                        end else begin
                            frame_err_o <= 1'b1;
                            state_q     <= Break;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                Break: begin
                    if (rs) begin
                        state_q <= Idle;
                        armed_q <= 1'b1;
                    end
                end
                default: state_q <= Idle;
            endcase
        end
    end

endmodule

// File: rtl/sim_uart_rx_hub.sv
// N-channel UART receive hub: per-channel receiver and FIFO,
// round-robin merge onto one tagged valid/ready byte stream.
module sim_uart_rx_hub
    import sim_uart_pkg::*;
#(
    parameter int NumChannels    = 2,
    parameter int ClockFrequency = 50_000_000,
    parameter int BaudRate       = 115_200,
    parameter int FifoDepth      = 8,
    localparam int ChanW         = chan_w(NumChannels)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumChannels-1:0] rx_i,
    output logic [7:0]             byte_o,
    output logic [ChanW-1:0]       chan_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [NumChannels-1:0] frame_err_o,
    output logic [NumChannels-1:0] overflow_o,
    input  logic                   clear_i
);

    localparam int ClksPerBit = clks_per_bit(ClockFrequency, BaudRate);
    localparam int AddrW      = $clog2(FifoDepth);

    logic [7:0]             mem_q [NumChannels][FifoDepth];
    logic [AddrW:0]         wp_q  [NumChannels];
    logic [AddrW:0]         rp_q  [NumChannels];
    logic [7:0]             rx_data [NumChannels];
    logic [NumChannels-1:0] push;
    logic [NumChannels-1:0] ferr;
    logic [NumChannels-1:0] empty;
    logic [NumChannels-1:0] full;
    logic [NumChannels-1:0] pop;
    logic [NumChannels-1:0] wr_en;
    logic [NumChannels-1:0] ovf_set;
    logic [ChanW-1:0]       rr_q;
    logic [ChanW-1:0]       win;
    logic [ChanW-1:0]       cand;
    logic                   found;
    logic                   load;

    assign load    = !valid_o || ready_i;
    assign ovf_set = push & full & ~pop;

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        sim_uart_rx #(
            .ClksPerBit(ClksPerBit)
        ) u_rx (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .rx_i       (rx_i[c]),
            .push_o     (push[c]),
            .data_o     (rx_data[c]),
            .frame_err_o(ferr[c])
        );

        assign empty[c] = wp_q[c] == rp_q[c];
        assign full[c]  = (wp_q[c][AddrW] != rp_q[c][AddrW]) &&
                          (wp_q[c][AddrW-1:0] == rp_q[c][AddrW-1:0]);
        assign pop[c]   = load && found && (win == ChanW'(c));
        // A pop in the same cycle frees the slot the push needs.
        assign wr_en[c] = push[c] && (!full[c] || pop[c]);
    end

    // Round-robin pick: first non-empty FIFO at or after rr_q.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NumChannels; i++) begin
            cand = ChanW'((int'(rr_q) + i) % NumChannels);
            if (!found && !empty[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // FIFO read/write pointers, one extra bit to tell full from empty.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int c = 0; c < NumChannels; c++) begin
                wp_q[c] <= '0;
                rp_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                if (wr_en[c]) wp_q[c] <= wp_q[c] + 1'b1;
                if (pop[c])   rp_q[c] <= rp_q[c] + 1'b1;
            end
        end
    end

    // FIFO storage, written only when a push is accepted.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumChannels; c++) begin
            if (wr_en[c]) mem_q[c][wp_q[c][AddrW-1:0]] <= rx_data[c];
        end
    end

    // Sticky error flags; a new event wins over a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            frame_err_o <= '0;
            overflow_o  <= '0;
        end else begin
            frame_err_o <= ferr | (clear_i ? '0 : frame_err_o);
            overflow_o  <= ovf_set | (clear_i ? '0 : overflow_o);
        end
    end

    // Output register: reloads when empty or when its byte is taken.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            byte_o  <= '0;
            chan_o  <= '0;
            rr_q    <= '0;
        end else if (load) begin
            valid_o <= found;
            if (found) begin
                byte_o <= mem_q[win][rp_q[win][AddrW-1:0]];
                chan_o <= win;
                rr_q   <= ChanW'((int'(win) + 1) % NumChannels);
            end
        end
    end

endmodule
